// File: rtl/boot_pkg.sv
// Shared definitions for the bootloader AHB write stage: FSM encoding,
// AHB-Lite attribute constants and header field width.
package boot_pkg;

    localparam int HDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // Little-endian lane merge: lane 0 lands in [7:0].
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        return word | ({24'h0, b} << {lane, 3'b000});
    endfunction

endpackage

// File: rtl/boot_word_fifo.sv
// Synchronous 32-bit word FIFO between the byte packer and the AHB engine.
// Latency: a pushed word is visible on rdata the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; callers gate on full/empty.
module boot_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] wdata,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/boot_ahb_writer.sv
// Packs boot image bytes into words and writes them over AHB-Lite; BOOT_CHECKSUM_EN adds a trailing checksum byte.
// Latency: completing byte -> NONSEQ 2 cycles later (empty FIFO, hready=1), hwdata 1 cycle after that.
// Backpressure: byte_ready drops only when the FIFO is full and the byte would complete a word.
module boot_ahb_writer
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hdr_valid,
    input  logic [HDR_W-1:0] hdr_num_bytes,
    input  logic [HDR_W-1:0] hdr_start_addr,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic             spi_hready,
    input  logic             spi_hresp,
    output logic [31:0]      spi_haddr,
    output logic             spi_hwrite,
    output logic [2:0]       spi_hsize,
    output logic [2:0]       spi_hburst,
    output logic             spi_hmastlock,
    output logic [3:0]       spi_hprot,
    output logic [1:0]       spi_htrans,
    output logic [31:0]      spi_hwdata,
    output logic             core_rst,
    output logic             load_done,
    output logic             load_err
);

    state_e           state_q, state_d;
    logic [HDR_W-1:0] num_bytes_q, num_bytes_d;
    logic [HDR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]      pack_q, pack_d;
    logic [1:0]       lane_q, lane_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      pend_q, pend_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic             dphase_q, dphase_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             data_done;
`else
    logic             last_byte;
`endif

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]      fifo_wdata, fifo_rdata;
    logic             aphase, engine_on;
    logic [HDR_W-1:0] byte_cnt_inc;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^hdr_start_addr[1:0];

    assign spi_hwrite    = 1'b1;
    assign spi_hsize     = HSIZE_WORD;
    assign spi_hburst    = HBURST_SINGLE;
    assign spi_hmastlock = 1'b0;
    assign spi_hprot     = HPROT_DATA;
    assign spi_htrans    = htrans_q;
    assign spi_haddr     = haddr_q;
    assign spi_hwdata    = hwdata_q;
    assign core_rst      = (state_q != ST_DONE);
    assign load_done     = (state_q == ST_DONE);
    assign load_err      = (state_q == ST_ERR);

    assign aphase       = (htrans_q == HTRANS_NONSEQ);
    assign engine_on    = (state_q == ST_LOAD) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
    assign byte_cnt_inc = byte_cnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
    assign data_done    = (byte_cnt_q == num_bytes_q);
`else
    assign last_byte    = (byte_cnt_inc == num_bytes_q);
`endif

    boot_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        num_bytes_d = num_bytes_q;
        byte_cnt_d  = byte_cnt_q;
        pack_d      = pack_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        dphase_d    = dphase_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        fifo_push   = 1'b0;
        fifo_wdata  = pack_q;
        fifo_pop    = 1'b0;
        byte_ready  = 1'b0;

        // The word is popped into pend_q when its address phase is issued,
        // so the FIFO slot frees up one cycle earlier than the data phase.
        if (engine_on) begin
            if (spi_hready) begin
                dphase_d = aphase;
                htrans_d = HTRANS_IDLE;
                if (aphase) begin
                    hwdata_d = pend_q;
                end
            end
            if (!fifo_empty && (!aphase || spi_hready)) begin
                fifo_pop = 1'b1;
                pend_d   = fifo_rdata;
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = addr_q;
                addr_d   = addr_q + 32'd4;
            end
        end

        if (state_q == ST_LOAD) begin
`ifdef BOOT_CHECKSUM_EN
            byte_ready = data_done || !(fifo_full && lane_q == 2'd3);
`else
            byte_ready = !(fifo_full && lane_q == 2'd3);
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (hdr_valid) begin
                    num_bytes_d = hdr_num_bytes;
                    byte_cnt_d  = '0;
                    addr_d      = BASE_ADDR + {16'h0, hdr_start_addr[15:2], 2'b00};
                    // An empty image has nothing to write or checksum.
                    state_d     = (hdr_num_bytes == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (byte_valid) begin
                    if (!byte_ready) begin
                        state_d = ST_ERR;
                    end
`ifdef BOOT_CHECKSUM_EN
                    else if (data_done) begin
                        if (csum_q + byte_data != 8'h00) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = (lane_q != 2'd0) ? ST_FLUSH : ST_DRAIN;
                        end
                    end
`endif
                    else begin
                        byte_cnt_d = byte_cnt_inc;
                        if (lane_q == 2'd3) begin
                            fifo_push  = 1'b1;
                            fifo_wdata = lane_insert(pack_q, lane_q, byte_data);
                            pack_d     = '0;
                            lane_d     = 2'd0;
                        end else begin
                            pack_d = lane_insert(pack_q, lane_q, byte_data);
                            lane_d = lane_q + 2'd1;
                        end
`ifdef BOOT_CHECKSUM_EN
                        csum_d = csum_q + byte_data;
`else
                        if (last_byte) begin
                            state_d = (lane_q == 2'd3) ? ST_DRAIN : ST_FLUSH;
                        end
`endif
                    end
                end
            end
            ST_FLUSH: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    pack_d    = '0;
                    lane_d    = 2'd0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !aphase && (!dphase_q || spi_hready)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
            end
        endcase

        if (engine_on && dphase_q && spi_hresp) begin
            state_d = ST_ERR;
        end
        if (state_d == ST_ERR) begin
            htrans_d = HTRANS_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_bytes_q <= '0;
            byte_cnt_q  <= '0;
            pack_q      <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            pend_q      <= '0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            dphase_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            num_bytes_q <= num_bytes_d;
            byte_cnt_q  <= byte_cnt_d;
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            dphase_q    <= dphase_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
